pio_gpio_ex: RTL and testbench
==============================

PIO_GPIO_EX -- requirements
Module: pio_gpio_ex

Interface
REQ-001 Parameter WIDTH, default 10, number of PIO bits; legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0, reset value of the output data register, WIDTH bits.
REQ-003 Parameter EDGE_TYPE, default 0, edge-capture mode: 0 = rising, 1 = falling, 2 = any.
REQ-004 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port address, input, 3, Avalon-MM slave word address.
REQ-007 Port chipselect, input, 1, slave select.
REQ-008 Port write_n, input, 1, active-low write strobe.
REQ-009 Port writedata, input, 32, write data; only bits [WIDTH-1:0] are used.
REQ-010 Port readdata, output, 32, read data; combinational, zero wait states; bits above WIDTH-1 read 0.
REQ-011 Port in_port, input, WIDTH, asynchronous external inputs.
REQ-012 Port out_port, output, WIDTH, registered output data.
REQ-013 Port oe_port, output, WIDTH, per-bit output enable (1 = drive).
REQ-014 Port irq, output, 1, level interrupt, active-high.

Function
REQ-015 The block SHALL define this register map, indexed by address:
- 0 DATA: read returns in_sync; write loads data_out.
- 1 DIR: R/W; 1 = output.
- 2 IRQMASK: R/W.
- 3 EDGECAP: read returns the capture register; write 1 clears the corresponding bit.
- 4 OUTSET: write ORs writedata into data_out; read returns 0.
- 5 OUTCLR: write clears data_out bits where writedata is 1; read returns 0.
- 6 OUTRB: read returns data_out; writes are ignored.
- 7: reads return 0; writes are ignored.
REQ-016 A write SHALL occur only when chipselect=1 and write_n=0, and SHALL take effect on the next rising clk edge.
REQ-017 in_port SHALL pass through a 2-flop synchroniser (in_sync), plus a third delayed copy (in_d) for edge detection.
REQ-018 Edge detection SHALL use the synchronised signals:
- rise = in_sync & ~in_d
- fall = ~in_sync & in_d
- EDGE_TYPE selects rise, fall, or rise|fall.
REQ-019 A detected edge SHALL set its EDGECAP bit; the bit holds until cleared by software, regardless of DIR.
REQ-020 If an edge is detected and an EDGECAP write-1-clear targets the same bit in the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-021 irq SHALL be registered, equal to |(EDGECAP & IRQMASK), and SHALL lag the cause by one cycle.
REQ-022 Latency from an in_port change to its EDGECAP bit becoming readable SHALL be 3 clk edges.
REQ-023 out_port SHALL equal data_out and oe_port SHALL equal DIR, both directly from registers.
REQ-024 Writes to DATA, OUTSET and OUTCLR SHALL update data_out independent of DIR.
REQ-025 For WIDTH=32, all 32 bits SHALL be functional; for WIDTH<32, unused writedata bits SHALL be ignored.
REQ-026 Reads SHALL have no side effects.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force:
- data_out = RESET_VALUE
- DIR = 0, IRQMASK = 0, EDGECAP = 0
- synchroniser and in_d flops = 0
- irq = 0
REQ-028 Reset asserted mid-operation SHALL discard any pending write and any edge in flight; no EDGECAP bit is set on release unless a new edge is detected after release.
REQ-029 After reset_n deasserts, the first write SHALL be accepted on the first rising clk edge.

Verification
REQ-030 Reset with WIDTH=10, RESET_VALUE=0x155 -> out_port=0x155, oe_port=0, irq=0, and a read of address 6 returns 0x00000155.
REQ-031 Write 0x0F0 to addr 0, then 0x00F to addr 4, then 0x030 to addr 5 -> out_port goes 0x0F0, then 0x0FF, then 0x0CF, each change one cycle after its write.
REQ-032 EDGE_TYPE=0, IRQMASK=0x001; drive in_port[0] 0->1 -> EDGECAP[0]=1 on the 3rd edge and irq=1 on the 4th; write 0x001 to addr 3 -> irq=0 one cycle after EDGECAP clears.
REQ-033 EDGE_TYPE=2; pulse in_port[3] high for 4 cycles -> EDGECAP[3] set by the rise, still 1 after the fall; IRQMASK=0 keeps irq=0 throughout.
REQ-034 Time a write-1-clear to addr 3 to land in the same cycle a new edge is detected on the same bit -> EDGECAP bit reads 1 afterwards.
REQ-035 WIDTH=32: write 0xFFFFFFFF to addr 1 -> oe_port=0xFFFFFFFF; a read of address 7 returns 0; a read of address 4 returns 0.

Source files
------------

// File: rtl/pio_gpio_ex_if.sv
// pio_gpio_ex_if: Avalon-MM slave bus carrying register accesses for pio_gpio_ex
interface pio_gpio_ex_if;
  logic [2:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_gpio_ex.sv
// pio_gpio_ex: Avalon-MM GPIO with direction, set/clear output, edge capture and level interrupt
module pio_gpio_ex #(
  parameter int WIDTH = 10,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic reset_n,
  pio_gpio_ex_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic irq
);
  logic [WIDTH-1:0] sync1, in_sync, in_d, data_out, dir, irqmask, edgecap, wd, edges, clr, rd;
  logic wr, unused_wd;
  assign wr = bus.chipselect & ~bus.write_n;
  assign wd = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  assign edges = EDGE_TYPE == 0 ? in_sync & ~in_d :
                 EDGE_TYPE == 1 ? ~in_sync & in_d : in_sync ^ in_d;
  assign clr = (wr && bus.address == 3'd3) ? wd : '0;
  always_comb begin
    rd = bus.address == 3'd0 ? in_sync :
         bus.address == 3'd1 ? dir :
         bus.address == 3'd2 ? irqmask :
         bus.address == 3'd3 ? edgecap :
         bus.address == 3'd6 ? data_out : '0;
  end
  assign bus.readdata = 32'(rd);
  assign out_port = data_out;
  assign oe_port = dir;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '0;
      in_sync <= '0;
      in_d <= '0;
      data_out <= RESET_VALUE[WIDTH-1:0];
      dir <= '0;
      irqmask <= '0;
      edgecap <= '0;
      irq <= 1'b0;
    end else begin
      sync1 <= in_port;
      in_sync <= sync1;
      in_d <= in_sync;
      // a freshly detected edge outranks a same-cycle software clear
      edgecap <= (edgecap & ~clr) | edges;
      irq <= |(edgecap & irqmask);
      data_out <= !wr ? data_out :
                  bus.address == 3'd0 ? wd :
                  bus.address == 3'd4 ? data_out | wd :
                  bus.address == 3'd5 ? data_out & ~wd : data_out;
      dir <= (wr && bus.address == 3'd1) ? wd : dir;
      irqmask <= (wr && bus.address == 3'd2) ? wd : irqmask;
    end
endmodule

// File: tb/tb_pio_gpio_ex.sv
// tb_pio_gpio_ex: scoreboard bench for a 10-bit rising-edge instance and a 32-bit any-edge instance
module tb_pio_gpio_ex;
  logic clk = 1'b0;
  logic reset_n;
  logic [9:0] in_a, out_a, oe_a;
  logic [31:0] in_b, out_b, oe_b;
  logic irq_a, irq_b;
  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_q[$];

  pio_gpio_ex_if bus_a();
  pio_gpio_ex_if bus_b();

  pio_gpio_ex #(.WIDTH(10), .RESET_VALUE(32'h155), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_a),
    .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

  pio_gpio_ex #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_b),
    .out_port(out_b), .oe_port(oe_b), .irq(irq_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic observe(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = exp_q.size() == 0 ? 32'hx : exp_q.pop_front();
    check(tag, got, e);
  endtask

  task automatic wr(input bit s, input logic [2:0] a, input logic [31:0] d);
    if (s) begin
      bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    end else begin
      bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    end
    @(negedge clk);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic rd(input bit s, input logic [2:0] a, input logic [31:0] want, input string tag);
    push(want);
    if (s) bus_b.address = a; else bus_a.address = a;
    #1;
    observe(tag, s ? bus_b.readdata : bus_a.readdata);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    in_a = '0; in_b = '0;
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    cyc(2);
    push(32'h155); observe("rst_out_a", 32'(out_a));
    push(32'h0);   observe("rst_oe_a", 32'(oe_a));
    push(32'h0);   observe("rst_irq_a", 32'(irq_a));
    rd(0, 3'd6, 32'h155, "rst_rd6_a");
    push(32'h0);   observe("rst_oe_b", oe_b);
    // release and write in the same cycle: first posedge after release must accept it
    reset_n = 1'b1;
    push(32'h0F0); wr(0, 3'd0, 32'h0F0); observe("data_wr", 32'(out_a));
    push(32'h0FF); wr(0, 3'd4, 32'h00F); observe("outset", 32'(out_a));
    push(32'h0CF); wr(0, 3'd5, 32'h030); observe("outclr", 32'(out_a));
    push(32'h0);   observe("oe_indep", 32'(oe_a));
    rd(0, 3'd6, 32'h0CF, "outrb_a");
    rd(0, 3'd4, 32'h0, "rd4_a");
    rd(0, 3'd5, 32'h0, "rd5_a");
    push(32'h003); wr(0, 3'd1, 32'hFFFF_F003); observe("dir_trunc", 32'(oe_a));
    rd(0, 3'd1, 32'h003, "rd_dir_a");
    wr(0, 3'd2, 32'h001);
    rd(0, 3'd2, 32'h001, "rd_mask_a");
    // rising edge on bit 0: capture after 3 edges, irq one edge later
    @(negedge clk);
    in_a[0] = 1'b1;
    cyc(2);
    rd(0, 3'd3, 32'h0, "ecap_2edge");
    cyc(1);
    rd(0, 3'd3, 32'h1, "ecap_3edge");
    push(32'h0); observe("irq_3edge", 32'(irq_a));
    cyc(1);
    push(32'h1); observe("irq_4edge", 32'(irq_a));
    wr(0, 3'd3, 32'h001);
    rd(0, 3'd3, 32'h0, "ecap_clr");
    push(32'h1); observe("irq_lag", 32'(irq_a));
    cyc(1);
    push(32'h0); observe("irq_clr", 32'(irq_a));
    in_a[0] = 1'b0;
    cyc(5);
    rd(0, 3'd3, 32'h0, "fall_ignored");
    push(32'h0); observe("fall_irq", 32'(irq_a));

    push(32'hFFFF_FFFF); wr(1, 3'd1, 32'hFFFF_FFFF); observe("oe32", oe_b);
    wr(1, 3'd0, 32'hA5A5_A5A5);
    push(32'hFFFF_A5A5); wr(1, 3'd4, 32'h5A5A_0000); observe("outset32", out_b);
    wr(1, 3'd7, 32'h1234_5678);
    rd(1, 3'd6, 32'hFFFF_A5A5, "outrb32");
    rd(1, 3'd7, 32'h0, "rd7_32");
    rd(1, 3'd4, 32'h0, "rd4_32");
    // any-edge mode with mask 0: capture persists, irq never rises
    @(negedge clk);
    in_b[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      push(32'h0); observe("irq_b_hi", 32'(irq_b));
    end
    rd(1, 3'd3, 32'h8, "ecap_rise_b");
    in_b[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      push(32'h0); observe("irq_b_lo", 32'(irq_b));
    end
    rd(1, 3'd3, 32'h8, "ecap_hold_b");
    in_b[5] = 1'b1;
    cyc(4);
    rd(1, 3'd3, 32'h28, "ecap5_set");
    // fall on bit 5 detected in the very cycle its clear lands
    @(negedge clk);
    in_b[5] = 1'b0;
    cyc(2);
    wr(1, 3'd3, 32'h20);
    rd(1, 3'd3, 32'h28, "set_wins");
    cyc(2);
    wr(1, 3'd3, 32'h28);
    rd(1, 3'd3, 32'h0, "clr_b");
    @(negedge clk);
    in_b = 32'h8000_0001;
    cyc(1);
    rd(1, 3'd0, 32'h0, "sync_1edge");
    cyc(1);
    rd(1, 3'd0, 32'h8000_0001, "sync_2edge");

    // reset mid-operation with an edge in flight and a pending write
    cyc(4);
    in_a[1] = 1'b1;
    cyc(1);
    reset_n = 1'b0;
    in_a = '0;
    bus_a.address = 3'd0; bus_a.writedata = 32'h3FF; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    cyc(1);
    push(32'h155); observe("midrst_out", 32'(out_a));
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    reset_n = 1'b1;
    cyc(5);
    rd(0, 3'd3, 32'h0, "midrst_ecap");
    rd(0, 3'd2, 32'h0, "midrst_mask");
    push(32'h155); observe("midrst_out2", 32'(out_a));
    push(32'h0);   observe("midrst_irq", 32'(irq_a));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
